// File: rtl/wb_cell_mux_if.sv
`default_nettype none
// ============================================================================
// wb_cell_mux_if : upstream Wishbone slave-port bundle for wb_cell_mux
// Revision: 1.0
// ============================================================================
interface wb_cell_mux_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_cell_mux.sv
`default_nettype none
// ============================================================================
// wb_cell_mux : Wishbone decoder/sequencer to NSLV cell slaves with watchdog
// Revision: 1.0
// ============================================================================
module wb_cell_mux #(
  parameter int          NSLV     = 4,
  parameter logic [7:0]  BASE     = 8'h30,
  parameter int          SEL_LSB  = 8,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  wb_cell_mux_if.slave           wbs,
  output logic [NSLV-1:0]        s_cyc_o,
  output logic [NSLV-1:0]        s_stb_o,
  output logic                   s_we_o,
  output logic [3:0]             s_sel_o,
  output logic [31:0]            s_adr_o,
  output logic [31:0]            s_dat_o,
  input  logic [32*NSLV-1:0]     s_dat_i,
  input  logic [NSLV-1:0]        s_ack_i,
  output logic                   err_irq,
  output logic [7:0]             err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_idx;
  logic [7:0]  r_timer, w_timer_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic        r_err, w_err_nxt;
  logic        w_latch;
  logic [7:0]  r_err_cnt;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;

  logic [2:0]      w_req_idx;
  logic            w_req;
  logic            w_hit;
  logic            w_timeout;
  logic            w_sel_ack;
  logic [31:0]     w_sel_dat;
  logic [NSLV-1:0] w_onehot;

  assign w_req_idx = wbs.wbs_adr_i[SEL_LSB+2:SEL_LSB];
  assign w_req     = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign w_hit     = (wbs.wbs_adr_i[31:24] == BASE) && ({1'b0, w_req_idx} < 4'(NSLV));
  assign w_timeout = (r_timer == 8'(TIMEOUT));

  always_comb begin
    w_sel_ack = 1'b0;
    w_sel_dat = '0;
    w_onehot  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_idx == 3'(i)) begin
        w_onehot[i] = 1'b1;
        w_sel_ack   = s_ack_i[i];
        w_sel_dat   = s_dat_i[32*i +: 32];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    w_latch     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_latch     = 1'b1;
          w_timer_nxt = '0;
          if (w_hit) begin
            w_state_nxt = S_ACTIVE;
            w_err_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_RESP;
            w_rdata_nxt = ERR_DATA;
            w_err_nxt   = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        // Abort beats everything; an ack beats a simultaneous timeout.
        if (!wbs.wbs_cyc_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_sel_ack) begin
          w_state_nxt = S_RESP;
          w_rdata_nxt = w_sel_dat;
          w_err_nxt   = 1'b0;
        end else if (w_timeout) begin
          w_state_nxt = S_RESP;
          w_rdata_nxt = ERR_DATA;
          w_err_nxt   = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_idx <= '0;
      r_we  <= 1'b0;
      r_sel <= '0;
      r_adr <= '0;
      r_dat <= '0;
    end else if (w_latch) begin
      r_idx <= w_req_idx;
      r_we  <= wbs.wbs_we_i;
      r_sel <= wbs.wbs_sel_i;
      r_adr <= wbs.wbs_adr_i;
      r_dat <= wbs.wbs_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_err_cnt <= '0;
    end else if ((r_state == S_RESP) && r_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign s_cyc_o       = (r_state == S_ACTIVE) ? w_onehot : '0;
  assign s_stb_o       = (r_state == S_ACTIVE) ? w_onehot : '0;
  assign s_we_o        = r_we;
  assign s_sel_o       = r_sel;
  assign s_adr_o       = r_adr;
  assign s_dat_o       = r_dat;
  assign wbs.wbs_ack_o = (r_state == S_RESP);
  assign wbs.wbs_dat_o = (r_state == S_RESP) ? r_rdata : '0;
  assign err_irq       = (r_state == S_RESP) & r_err;
  assign err_cnt       = r_err_cnt;

endmodule
`default_nettype wire
